// File: rtl/mem_pkg.sv
// Shared encodings for the memory responder: FSM states, op codes and legal
// byte-lane write masks, plus the mask legality check.
package mem_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    localparam logic [3:0] WB_B0 = 4'b0001;
    localparam logic [3:0] WB_B1 = 4'b0010;
    localparam logic [3:0] WB_B2 = 4'b0100;
    localparam logic [3:0] WB_B3 = 4'b1000;
    localparam logic [3:0] WB_H0 = 4'b0011;
    localparam logic [3:0] WB_H1 = 4'b1100;
    localparam logic [3:0] WB_W  = 4'b1111;

    // Only naturally aligned byte, halfword and word lane groups are accepted.
    function automatic logic wrbits_legal(input logic [3:0] mask);
        case (mask)
            WB_B0, WB_B1, WB_B2, WB_B3, WB_H0, WB_H1, WB_W: return 1'b1;
            default:                                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between the controller (master) and the memory
// responder (slave).
interface mem_responder_if;

    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_wrbits;
    logic [31:0] addr;
    logic [31:0] wrdata;
    logic [31:0] rddata;
    logic        rd_valid;
    logic        busy;
    logic        err;

    modport master (
        output mem_read, mem_write, mem_wrbits, addr, wrdata,
        input  rddata, rd_valid, busy, err
    );

    modport slave (
        input  mem_read, mem_write, mem_wrbits, addr, wrdata,
        output rddata, rd_valid, busy, err
    );

endinterface

// File: rtl/mem_bank.sv
// Word-organised RAM built from four byte lanes: synchronous read with enable,
// independent per-lane write enables.
module mem_bank #(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned ADDR_W    = 10,
  parameter              INIT_FILE = ""
) (
  input  logic              clock,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_idx,
  output logic [31:0]       rd_data,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] wr_idx,
  input  logic [31:0]       wr_data
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (rd_en) begin
      rd_data <= mem[rd_idx];
    end
    for (int unsigned i = 0; i < 4; i++) begin
      if (we[i]) begin
        mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts one request at a time, inserts LATENCY-1 wait
// cycles, then answers in RESP with registered read data, rd_valid and err.
module mem_responder #(
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned LATENCY   = 1,
    parameter              INIT_FILE = ""
) (
    input  logic           clock,
    input  logic           reset,
    mem_responder_if.slave bus
);

    import mem_pkg::*;

    localparam int unsigned ADDR_W     = $clog2(DEPTH);
    localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH);
    localparam logic [3:0]  WCNT_INIT  = 4'(LATENCY - 1);

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [3:0]  wcnt;
    logic [31:0] addr_q;
    logic [31:0] wrdata_q;
    logic [3:0]  wrbits_q;
    logic        op_q;
    logic        rd_valid_q;
    logic        err_q;

    logic        req;
    logic        go_resp;
    logic        sel_op;
    logic        sel_reject;
    logic [31:0] sel_addr;
    logic [3:0]  sel_wrbits;
    logic [31:0] bank_data;
    logic [3:0]  bank_we;

    assign req = bus.mem_read | bus.mem_write;

    // The RAM read and the error decision are made on the edge that enters
    // RESP; with LATENCY=1 that edge is the accept edge, so the live request
    // is used in IDLE and the latched copy otherwise.
    always_comb begin
        sel_addr   = addr_q;
        sel_wrbits = wrbits_q;
        sel_op     = op_q;
        if (state == S_IDLE) begin
            sel_addr   = bus.addr;
            sel_wrbits = bus.mem_wrbits;
            sel_op     = bus.mem_write ? OP_WR : OP_RD;
        end
        sel_reject = (sel_addr >= ADDR_LIMIT) ||
                     ((sel_op == OP_WR) && !wrbits_legal(sel_wrbits));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (req) state_nxt = (WCNT_INIT == 4'd0) ? S_RESP : S_WAIT;
            S_WAIT: if (wcnt == 4'd1) state_nxt = S_RESP;
            S_RESP: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign go_resp = (state_nxt == S_RESP);

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            wcnt       <= '0;
            addr_q     <= '0;
            wrdata_q   <= '0;
            wrbits_q   <= '0;
            op_q       <= OP_RD;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state <= state_nxt;
            if ((state == S_IDLE) && req) begin
                addr_q   <= bus.addr;
                wrdata_q <= bus.wrdata;
                wrbits_q <= bus.mem_wrbits;
                op_q     <= sel_op;
                wcnt     <= WCNT_INIT;
            end else if (state == S_WAIT) begin
                wcnt <= wcnt - 4'd1;
            end
            rd_valid_q <= go_resp && (sel_op == OP_RD);
            err_q      <= go_resp && sel_reject;
        end
    end

    // Write commits on the edge leaving RESP; a reset on that edge cancels it.
    assign bank_we = ((state == S_RESP) && (op_q == OP_WR) && !err_q && !reset)
                     ? wrbits_q : '0;

    mem_bank #(
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W),
        .INIT_FILE (INIT_FILE)
    ) u_bank (
        .clock   (clock),
        .rd_en   (go_resp && (sel_op == OP_RD) && !sel_reject),
        .rd_idx  (sel_addr[ADDR_W+1:2]),
        .rd_data (bank_data),
        .we      (bank_we),
        .wr_idx  (addr_q[ADDR_W+1:2]),
        .wr_data (wrdata_q)
    );

    assign bus.rddata   = (rd_valid_q && !err_q) ? bank_data : '0;
    assign bus.rd_valid = rd_valid_q;
    assign bus.err      = err_q;
    assign bus.busy     = (state != S_IDLE);

endmodule
